// File: rtl/muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// Holds the decoded R-type funct codes, the iteration FSM state type and the
// default operand width.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side bundle for ex_muldiv_unit.
//   master : ID/EX + hazard side (drives valid/fun/operands/flush)
//   slave  : the mul/div unit (drives stall/busy/done/rdata/hi/lo)
interface ex_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            valid;
  logic [5:0]      fun;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] rdata;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output valid, fun, rs_val, rt_val, flush,
    input  stall, busy, done, rdata, hi, lo
  );

  modport slave (
    input  valid, fun, rs_val, rt_val, flush,
    output stall, busy, done, rdata, hi, lo
  );
endinterface

// File: rtl/muldiv_iter_core.sv
// Iterative unsigned datapath: radix-2 shift-add multiply and (when
// MULDIV_DIV_EN is defined) restoring divide, one bit per step.
//   load_i   : capture op_a_i into the low half of the accumulator, op_b_i
//              as multiplicand/divisor, clear the counter
//   step_i   : perform one iteration
//   is_div_i : select divide iteration (only present with MULDIV_DIV_EN)
//   acc_o    : {product} or {remainder, quotient}
//   last_o   : counter is on its final iteration
module muldiv_iter_core #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
`ifdef MULDIV_DIV_EN
  input  logic              is_div_i,
`endif
  input  logic [XLEN-1:0]   op_a_i,
  input  logic [XLEN-1:0]   op_b_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              last_o
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Multiply: add multiplicand into the upper half when the LSB is set,
  // then shift the whole accumulator right (carry enters the top).
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

`ifdef MULDIV_DIV_EN
  // Divide: shift left, trial-subtract divisor from the partial remainder,
  // keep the difference and set the quotient bit when it does not borrow.
  logic [2*XLEN:0]   div_sh;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  assign div_sh   = {acc_q, 1'b0};
  assign div_diff = div_sh[2*XLEN:XLEN] - {1'b0, b_q};
  assign div_next = div_diff[XLEN] ? div_sh[2*XLEN-1:0]
                                   : {div_diff[XLEN-1:0], div_sh[XLEN-1:1], 1'b1};
`endif

  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    if (load_i) begin
      acc_d = {XLEN'(0), op_a_i};
      b_d   = op_b_i;
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + CNT_W'(1);
`ifdef MULDIV_DIV_EN
      acc_d = is_div_i ? div_next : mul_next;
`else
      acc_d = mul_next;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (cnt_q == CNT_W'(XLEN - 1));

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage iterative multiply/divide unit with HI/LO registers.
// Ports: clk, rst_n (async active-low) and bus (ex_muldiv_unit_if.slave):
//   valid/fun/rs_val/rt_val/flush in; stall/busy/done/rdata/hi/lo out.
// Optional: define MULDIV_DIV_EN to include div/divu; without it those
// funct codes are ignored like any unrecognised funct.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = muldiv_pkg::XLEN,
  parameter int unsigned CNT_W = 5
) (
  input logic             clk,
  input logic             rst_n,
  ex_muldiv_unit_if.slave bus
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic            done_q, done_d;
`ifdef MULDIV_DIV_EN
  logic            is_div_q, is_div_d, div0_q, div0_d;
`endif

  logic [2*XLEN-1:0] acc;
  logic              last;

  logic            op_mul, op_div, op_signed, op_hilo, accept, busy;
  logic            rs_neg, rt_neg;
  logic [XLEN-1:0] op_a, op_b;

  assign op_mul = (bus.fun == F_MULT) || (bus.fun == F_MULTU);
`ifdef MULDIV_DIV_EN
  assign op_div = (bus.fun == F_DIV) || (bus.fun == F_DIVU);
`else
  assign op_div = 1'b0;
`endif
  assign op_signed = (bus.fun == F_MULT) || (bus.fun == F_DIV);
  assign op_hilo   = op_mul || op_div ||
                     (bus.fun == F_MFHI) || (bus.fun == F_MTHI) ||
                     (bus.fun == F_MFLO) || (bus.fun == F_MTLO);

  assign busy   = (state_q != IDLE);
  assign accept = (state_q == IDLE) && bus.valid && !bus.flush && (op_mul || op_div);

  // The core works on magnitudes; signs are reapplied in FIX.
  assign rs_neg = op_signed && bus.rs_val[XLEN-1];
  assign rt_neg = op_signed && bus.rt_val[XLEN-1];
  assign op_a   = rs_neg ? -bus.rs_val : bus.rs_val;
  assign op_b   = rt_neg ? -bus.rt_val : bus.rt_val;

  muldiv_iter_core #(
    .XLEN (XLEN),
    .CNT_W(CNT_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept),
    .step_i  (state_q == RUN),
`ifdef MULDIV_DIV_EN
    .is_div_i(is_div_q),
`endif
    .op_a_i  (op_a),
    .op_b_i  (op_b),
    .acc_o   (acc),
    .last_o  (last)
  );

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   res_hi, res_lo;
  assign prod = (sign_a_q ^ sign_b_q) ? -acc : acc;

`ifdef MULDIV_DIV_EN
  // Divide-by-zero leaves the dividend magnitude as remainder, so the usual
  // remainder sign fix already restores the raw dividend into HI; only LO
  // needs forcing. 0x80000000 / -1 falls out of the magnitude path unaided.
  logic [XLEN-1:0] rem, quo;
  assign rem = acc[2*XLEN-1:XLEN];
  assign quo = acc[XLEN-1:0];
  always_comb begin
    if (is_div_q) begin
      res_hi = sign_a_q ? -rem : rem;
      res_lo = div0_q ? '1 : ((sign_a_q ^ sign_b_q) ? -quo : quo);
    end else begin
      res_hi = prod[2*XLEN-1:XLEN];
      res_lo = prod[XLEN-1:0];
    end
  end
`else
  assign res_hi = prod[2*XLEN-1:XLEN];
  assign res_lo = prod[XLEN-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    done_d   = 1'b0;
`ifdef MULDIV_DIV_EN
    is_div_d = is_div_q;
    div0_d   = div0_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = RUN;
          sign_a_d = rs_neg;
          sign_b_d = rt_neg;
`ifdef MULDIV_DIV_EN
          is_div_d = op_div;
          div0_d   = (bus.rt_val == '0);
`endif
        end else if (bus.valid && !bus.flush) begin
          if (bus.fun == F_MTHI) hi_d = bus.rs_val;
          if (bus.fun == F_MTLO) lo_d = bus.rs_val;
        end
      end
      RUN: begin
        if (bus.flush)  state_d = IDLE;
        else if (last)  state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.flush) begin
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      done_q   <= done_d;
`ifdef MULDIV_DIV_EN
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
`endif
    end
  end

  logic stall;
  assign stall = bus.valid && op_hilo && busy;

  always_comb begin
    bus.rdata = '0;
    if (bus.valid && !stall) begin
      if (bus.fun == F_MFHI) bus.rdata = hi_q;
      if (bus.fun == F_MFLO) bus.rdata = lo_q;
    end
  end

  assign bus.stall = stall;
  assign bus.busy  = busy;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule
